// File: rtl/wdt_service_ctrl_if.sv
// Signal bundle between the watchdog service controller and its environment
// (software key port, timer enable/timeout, interrupt and reset request).
interface wdt_service_ctrl_if;
    // Handshake: key_valid, arm and irq_clr are single-cycle strobes with no
    // ready; the controller takes every strobe on the rising edge it is seen.
    logic        wdt_to;
    logic        wdt_en;
    logic        arm;
    logic        key_valid;
    logic [31:0] key_data;
    logic        irq_clr;
    logic        irq;
    logic        sys_rst_req;
    logic [7:0]  to_count;
    logic [1:0]  state;

    modport master (
        output wdt_to, arm, key_valid, key_data, irq_clr,
        input  wdt_en, irq, sys_rst_req, to_count, state
    );

    modport slave (
        input  wdt_to, arm, key_valid, key_data, irq_clr,
        output wdt_en, irq, sys_rst_req, to_count, state
    );
endinterface

// File: rtl/wdt_service_ctrl.sv
// Watchdog service/escalation controller: turns a two-key software sequence
// into a one-cycle timer reload, warns on first timeout, resets on the second.
module wdt_service_ctrl #(
    parameter int unsigned RST_PULSE_W = 16,
    parameter logic [31:0] KEY1        = 32'hA5A5_5A5A,
    parameter logic [31:0] KEY2        = 32'h5A5A_A5A5
) (
    input  logic              clk,
    input  logic              rst,
    wdt_service_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_DISABLED  = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_WARNED    = 2'd2,
        ST_RESETTING = 2'd3
    } state_e;

    localparam logic [7:0] PULSE_LAST = 8'(RST_PULSE_W - 1);

    state_e      state_q;
    logic        wdt_en_q;
    logic        irq_q;
    logic        sys_rst_req_q;
    logic        kick_arm_q;
    logic [7:0]  to_count_q;
    logic [7:0]  pulse_cnt_q;
    logic [7:0]  to_count_d;

    assign to_count_d = (to_count_q == 8'hFF) ? to_count_q : to_count_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_DISABLED;
            wdt_en_q      <= 1'b0;
            irq_q         <= 1'b0;
            sys_rst_req_q <= 1'b0;
            kick_arm_q    <= 1'b0;
            to_count_q    <= 8'd0;
            pulse_cnt_q   <= 8'd0;
        end else begin
            // A warning set later in this block overrides the clear.
            if (bus.irq_clr) begin
                irq_q <= 1'b0;
            end
            case (state_q)
                ST_DISABLED: begin
                    wdt_en_q   <= 1'b0;
                    kick_arm_q <= 1'b0;
                    if (bus.arm) begin
                        state_q  <= ST_RUNNING;
                        wdt_en_q <= 1'b1;
                    end
                end
                ST_RUNNING, ST_WARNED: begin
                    wdt_en_q <= 1'b1;
                    if (bus.wdt_to) begin
                        kick_arm_q <= 1'b0;
                        to_count_q <= to_count_d;
                        if (state_q == ST_RUNNING) begin
                            state_q <= ST_WARNED;
                            irq_q   <= 1'b1;
                        end else begin
                            state_q       <= ST_RESETTING;
                            wdt_en_q      <= 1'b0;
                            sys_rst_req_q <= 1'b1;
                            pulse_cnt_q   <= PULSE_LAST;
                        end
                    end else if (bus.key_valid) begin
                        if (bus.key_data == KEY1) begin
                            kick_arm_q <= 1'b1;
                        end else if (bus.key_data == KEY2 && kick_arm_q) begin
                            kick_arm_q <= 1'b0;
                            wdt_en_q   <= 1'b0;
                            state_q    <= ST_RUNNING;
                        end else begin
                            kick_arm_q <= 1'b0;
                        end
                    end
                end
                ST_RESETTING: begin
                    kick_arm_q <= 1'b0;
                    if (pulse_cnt_q == 8'd0) begin
                        state_q       <= ST_RUNNING;
                        wdt_en_q      <= 1'b1;
                        sys_rst_req_q <= 1'b0;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - 8'd1;
                    end
                end
                default: state_q <= ST_DISABLED;
            endcase
        end
    end

    assign bus.wdt_en      = wdt_en_q;
    assign bus.irq         = irq_q;
    assign bus.sys_rst_req = sys_rst_req_q;
    assign bus.to_count    = to_count_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_wdt_service_ctrl.sv
// Directed bench for wdt_service_ctrl with a small reloading timer model
// feeding wdt_to, plus a manual timeout request for cycle-exact cases.
module tb_wdt_service_ctrl;

    localparam logic [31:0] K1 = 32'hA5A5_5A5A;
    localparam logic [31:0] K2 = 32'h5A5A_A5A5;

    logic        clk;
    logic        rst;
    logic        to_req;
    logic        tmr_run;
    logic [31:0] tmr_load;
    logic [31:0] tmr_cnt;
    int          checks;
    int          errors;

    wdt_service_ctrl_if bus ();

    wdt_service_ctrl #(.RST_PULSE_W(16), .KEY1(K1), .KEY2(K2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer model: counts while enabled, fires combinationally at load-1,
    // reloads itself on timeout and whenever the enable is low.
    assign bus.wdt_to = bus.wdt_en &&
                        (to_req || (tmr_run && tmr_cnt == tmr_load - 32'd1));

    always_ff @(posedge clk) begin
        if (!bus.wdt_en || !tmr_run || bus.wdt_to) tmr_cnt <= 32'd0;
        else                                       tmr_cnt <= tmr_cnt + 32'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key_write(input logic [31:0] data);
        bus.key_valid = 1'b1;
        bus.key_data  = data;
        tick();
        bus.key_valid = 1'b0;
        bus.key_data  = 32'd0;
    endtask

    task automatic wait_to(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.wdt_to === 1'b1) seen = 1'b1;
            else tick();
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        to_req        = 1'b0;
        tmr_run       = 1'b0;
        tmr_load      = 32'd100;
        bus.arm       = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_data  = 32'd0;
        bus.irq_clr   = 1'b0;

        // Reset held two cycles, arm during reset must be ignored.
        tick();
        bus.arm = 1'b1;
        tick();
        check("rst_state",   {30'd0, bus.state}, 32'd0);
        check("rst_wdt_en",  {31'd0, bus.wdt_en}, 32'd0);
        check("rst_irq",     {31'd0, bus.irq}, 32'd0);
        check("rst_sysrst",  {31'd0, bus.sys_rst_req}, 32'd0);
        check("rst_count",   {24'd0, bus.to_count}, 32'd0);
        rst     = 1'b0;
        bus.arm = 1'b0;
        tick();
        check("arm_in_rst_ignored", {30'd0, bus.state}, 32'd0);

        // Arm and service every ~50 cycles against a load of 100.
        tmr_run  = 1'b1;
        tmr_load = 32'd100;
        bus.arm  = 1'b1;
        tick();
        bus.arm  = 1'b0;
        check("armed_state", {30'd0, bus.state}, 32'd1);
        check("armed_en",    {31'd0, bus.wdt_en}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 48; i++) tick();
            key_write(K1);
            check("svc_key1_en", {31'd0, bus.wdt_en}, 32'd1);
            key_write(K2);
            check("svc_kick_en_low", {31'd0, bus.wdt_en}, 32'd0);
            tick();
            check("svc_en_back", {31'd0, bus.wdt_en}, 32'd1);
            check("svc_state",   {30'd0, bus.state}, 32'd1);
            check("svc_count",   {24'd0, bus.to_count}, 32'd0);
        end

        // Bad key sequences.
        key_write(K1);
        key_write(32'd0);
        key_write(K2);
        check("bad_k1_0_k2", {31'd0, bus.wdt_en}, 32'd1);
        key_write(K2);
        check("bad_k2_alone", {31'd0, bus.wdt_en}, 32'd1);
        key_write(K1);
        key_write(K1);
        check("k1k1_no_kick_yet", {31'd0, bus.wdt_en}, 32'd1);
        key_write(K2);
        check("k1k1k2_kick", {31'd0, bus.wdt_en}, 32'd0);
        tick();
        check("k1k1k2_en_back", {31'd0, bus.wdt_en}, 32'd1);

        // Escalation with load 10 and no kicks.
        tmr_load = 32'd10;
        wait_to("wait_first_to");
        tick();
        check("warn_state", {30'd0, bus.state}, 32'd2);
        check("warn_irq",   {31'd0, bus.irq}, 32'd1);
        check("warn_count", {24'd0, bus.to_count}, 32'd1);
        check("warn_en",    {31'd0, bus.wdt_en}, 32'd1);
        wait_to("wait_second_to");
        tick();
        check("resetting_state", {30'd0, bus.state}, 32'd3);
        check("resetting_en",    {31'd0, bus.wdt_en}, 32'd0);
        check("resetting_count", {24'd0, bus.to_count}, 32'd2);
        cnt = 0;
        while (bus.sys_rst_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        check("pulse_width",  cnt, 32'd16);
        check("post_pulse_state", {30'd0, bus.state}, 32'd1);
        check("post_pulse_en",    {31'd0, bus.wdt_en}, 32'd1);

        // Recovery from WARNED by a kick; irq survives until cleared.
        wait_to("wait_third_to");
        tick();
        check("warn2_state", {30'd0, bus.state}, 32'd2);
        key_write(K1);
        key_write(K2);
        check("recover_state", {30'd0, bus.state}, 32'd1);
        check("recover_irq",   {31'd0, bus.irq}, 32'd1);
        check("recover_en",    {31'd0, bus.wdt_en}, 32'd0);
        check("recover_count", {24'd0, bus.to_count}, 32'd3);
        bus.irq_clr = 1'b1;
        tick();
        bus.irq_clr = 1'b0;
        check("irq_cleared", {31'd0, bus.irq}, 32'd0);

        // Kick completion colliding with a timeout in RUNNING.
        tmr_run = 1'b0;
        tick();
        key_write(K1);
        bus.key_valid = 1'b1;
        bus.key_data  = K2;
        to_req        = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        to_req        = 1'b0;
        check("prio_run_state", {30'd0, bus.state}, 32'd2);
        check("prio_run_en",    {31'd0, bus.wdt_en}, 32'd1);
        check("prio_run_count", {24'd0, bus.to_count}, 32'd4);
        check("prio_run_irq",   {31'd0, bus.irq}, 32'd1);
        key_write(K2);
        check("prio_arm_cleared_en",    {31'd0, bus.wdt_en}, 32'd1);
        check("prio_arm_cleared_state", {30'd0, bus.state}, 32'd2);

        // Back to RUNNING, then irq set and irq_clr in the same cycle.
        key_write(K1);
        key_write(K2);
        check("kick2_state", {30'd0, bus.state}, 32'd1);
        tick();
        bus.irq_clr = 1'b1;
        to_req      = 1'b1;
        tick();
        bus.irq_clr = 1'b0;
        to_req      = 1'b0;
        check("set_beats_clr_irq",   {31'd0, bus.irq}, 32'd1);
        check("set_beats_clr_state", {30'd0, bus.state}, 32'd2);
        check("set_beats_clr_count", {24'd0, bus.to_count}, 32'd5);

        // Kick collision in WARNED escalates, then reset at pulse cycle 5.
        key_write(K1);
        bus.key_valid = 1'b1;
        bus.key_data  = K2;
        to_req        = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        to_req        = 1'b0;
        check("prio_warn_state",  {30'd0, bus.state}, 32'd3);
        check("prio_warn_sysrst", {31'd0, bus.sys_rst_req}, 32'd1);
        check("prio_warn_count",  {24'd0, bus.to_count}, 32'd6);
        for (int i = 0; i < 4; i++) tick();
        check("pulse_cycle5_high", {31'd0, bus.sys_rst_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midpulse_rst_sysrst", {31'd0, bus.sys_rst_req}, 32'd0);
        check("midpulse_rst_state",  {30'd0, bus.state}, 32'd0);
        check("midpulse_rst_en",     {31'd0, bus.wdt_en}, 32'd0);
        check("midpulse_rst_irq",    {31'd0, bus.irq}, 32'd0);
        check("midpulse_rst_count",  {24'd0, bus.to_count}, 32'd0);

        // Saturation: 300 forced timeouts.
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int i = 0; i < 300; i++) begin
            to_req = 1'b1;
            tick();
            to_req = 1'b0;
            cnt = 0;
            while (bus.state === 2'd3 && cnt < 40) begin
                cnt++;
                tick();
            end
            if (i == 9) check("count_10", {24'd0, bus.to_count}, 32'd10);
        end
        check("count_saturated", {24'd0, bus.to_count}, 32'd255);
        to_req = 1'b1;
        tick();
        to_req = 1'b0;
        check("count_no_wrap", {24'd0, bus.to_count}, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
